// File: rtl/mips_icache_dm.sv
// Direct-mapped, read-only, one-word-per-line cache between the CPU fetch port and dummy_ram.
// Hits answer on the accepting edge; misses fetch the word from memory, fill the line, then answer.
module mips_icache_dm #(
   parameter int INDEX_BITS = 2,
   parameter int CNT_BITS   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         cpu_addr,
   input  logic                cpu_read_en,
   output logic [31:0]         cpu_data,
   output logic                cpu_dvalid,
   input  logic                flush,
   output logic [31:0]         mem_addr,
   output logic                mem_read_en,
   input  logic [31:0]         mem_data,
   input  logic                mem_dvalid,
   output logic [CNT_BITS-1:0] hit_count,
   output logic [CNT_BITS-1:0] miss_count
);

   // state  | meaning
   // S_IDLE | waiting for a request; flush clears all lines
   // S_FILL | miss outstanding at dummy_ram, waiting for mem_dvalid
   // S_DONE | cpu_dvalid pulse cycle; read_en and flush ignored

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 32 - INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [LINES-1:0]    valid;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];
   logic [31:0]         req_addr;

   logic [INDEX_BITS-1:0] cpu_idx;
   logic [TAG_BITS-1:0]   cpu_tag;
   logic [INDEX_BITS-1:0] req_idx;
   logic [TAG_BITS-1:0]   req_tag;
   logic                  hit;

   logic accept;
   logic do_flush;
   logic fill_done;

   assign cpu_idx = cpu_addr[INDEX_BITS-1:0];
   assign cpu_tag = cpu_addr[31:INDEX_BITS];
   assign req_idx = req_addr[INDEX_BITS-1:0];
   assign req_tag = req_addr[31:INDEX_BITS];
   assign hit     = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);

   // read_en must already be low in the dvalid cycle, otherwise dummy_ram restarts a read.
   assign mem_read_en = (state == S_FILL) && !mem_dvalid && !reset;
   assign mem_addr    = req_addr;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      do_flush  = 1'b0;
      fill_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (flush) begin
               do_flush = 1'b1;
            end else if (cpu_read_en) begin
               accept    = 1'b1;
               state_nxt = hit ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            if (mem_dvalid) begin
               fill_done = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         valid      <= '0;
         cpu_dvalid <= 1'b0;
         cpu_data   <= '0;
         req_addr   <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state      <= state_nxt;
         cpu_dvalid <= (accept && hit) || fill_done;
         if (accept) begin
            req_addr <= cpu_addr;
         end
         if (accept && hit) begin
            cpu_data <= data_mem[cpu_idx];
         end else if (fill_done) begin
            cpu_data <= mem_data;
         end
         if (do_flush) begin
            valid <= '0;
         end else if (fill_done) begin
            valid[req_idx] <= 1'b1;
         end
         if (accept && hit && (hit_count != '1)) begin
            hit_count <= hit_count + CNT_BITS'(1);
         end
         if (accept && !hit && (miss_count != '1)) begin
            miss_count <= miss_count + CNT_BITS'(1);
         end
      end
   end

   // Line payload carries no reset; valid bits alone decide whether it is usable.
   always_ff @(posedge clk) begin
      if (!reset && fill_done) begin
         tag_mem[req_idx]  <= req_tag;
         data_mem[req_idx] <= mem_data;
      end
   end

endmodule

// File: tb/tb_mips_icache_dm.sv
// Directed bench for mips_icache_dm with a behavioural dummy_ram and a narrow-counter twin
// instance that shares all inputs to observe counter saturation.
module tb_mips_icache_dm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic        cpu_read_en;
   logic [31:0] cpu_data;
   logic        cpu_dvalid;
   logic        flush;
   logic [31:0] mem_addr;
   logic        mem_read_en;
   logic [31:0] mem_data;
   logic        mem_dvalid;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   logic [31:0] sat_cpu_data;
   logic        sat_cpu_dvalid;
   logic [31:0] sat_mem_addr;
   logic        sat_mem_read_en;
   logic [1:0]  sat_hit_count;
   logic [1:0]  sat_miss_count;

   logic [31:0] mem [16];
   int          dvalid_delay;
   int          ram_cnt;
   logic        ram_clr;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mips_icache_dm #(.INDEX_BITS(2), .CNT_BITS(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_read_en(cpu_read_en),
      .cpu_data   (cpu_data),
      .cpu_dvalid (cpu_dvalid),
      .flush      (flush),
      .mem_addr   (mem_addr),
      .mem_read_en(mem_read_en),
      .mem_data   (mem_data),
      .mem_dvalid (mem_dvalid),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   mips_icache_dm #(.INDEX_BITS(2), .CNT_BITS(2)) dut_sat (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_read_en(cpu_read_en),
      .cpu_data   (sat_cpu_data),
      .cpu_dvalid (sat_cpu_dvalid),
      .flush      (flush),
      .mem_addr   (sat_mem_addr),
      .mem_read_en(sat_mem_read_en),
      .mem_data   (mem_data),
      .mem_dvalid (mem_dvalid),
      .hit_count  (sat_hit_count),
      .miss_count (sat_miss_count)
   );

   // dummy_ram: dvalid pulses after read_en has been sampled high dvalid_delay+1 times.
   always @(posedge clk) begin
      if (ram_clr) begin
         ram_cnt    <= 0;
         mem_dvalid <= 1'b0;
      end else if (mem_read_en) begin
         if (ram_cnt == dvalid_delay) begin
            mem_dvalid <= 1'b1;
            mem_data   <= mem[mem_addr[3:0]];
            ram_cnt    <= 0;
         end else begin
            mem_dvalid <= 1'b0;
            ram_cnt    <= ram_cnt + 1;
         end
      end else begin
         mem_dvalid <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Latency = posedges from presenting the request until cpu_dvalid is seen (hit 1, miss D+3).
   task automatic do_read(input string tag, input logic [31:0] addr, input int exp_lat,
                          input logic [31:0] exp_data, input int exp_ren);
      int   lat;
      int   ren;
      logic addr_bad;
      lat = 0; ren = 0; addr_bad = 1'b0;
      cpu_addr    = addr;
      cpu_read_en = 1'b1;
      while (lat < 40) begin
         tick();
         lat++;
         if (mem_read_en) begin
            ren++;
            if (mem_addr !== addr) addr_bad = 1'b1;
         end
         if (cpu_dvalid) break;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_data"}, cpu_data, exp_data);
      chk({tag, "_ren_cycles"}, 32'(ren), 32'(exp_ren));
      chk({tag, "_mem_addr"}, {31'd0, addr_bad}, 32'd0);
      cpu_read_en = 1'b0;
      tick();
      chk({tag, "_dvalid_width"}, {31'd0, cpu_dvalid}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[1] = 32'h00C0FFEE;
      mem[2] = 32'h2222_0002;
      mem[5] = 32'hDEADBEEF;
      mem[7] = 32'h7777_0007;
      dvalid_delay = 1;
      ram_clr      = 1'b1;
      reset        = 1'b1;
      cpu_addr     = 32'd0;
      cpu_read_en  = 1'b0;
      flush        = 1'b0;
      tick();
      tick();
      reset   = 1'b0;
      ram_clr = 1'b0;
      tick();

      chk("rst_dvalid", {31'd0, cpu_dvalid}, 32'd0);
      chk("rst_data", cpu_data, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_read_en", {31'd0, mem_read_en}, 32'd0);
      chk("rst_counts", {hit_count, miss_count}, 32'd0);

      // 1: cold miss
      do_read("cold", 32'd5, 4, 32'hDEADBEEF, 2);
      chk("cold_miss_count", 32'(miss_count), 32'd1);
      chk("cold_hit_count", 32'(hit_count), 32'd0);

      // 2: hit
      do_read("hit", 32'd5, 1, 32'hDEADBEEF, 0);
      chk("hit_hit_count", 32'(hit_count), 32'd1);

      // back-to-back hits with read_en held: DONE ignores the request, next IDLE takes it
      cpu_addr = 32'd5; cpu_read_en = 1'b1;
      tick(); chk("b2b_e0", {31'd0, cpu_dvalid}, 32'd1);
      tick(); chk("b2b_e1", {31'd0, cpu_dvalid}, 32'd0);
      tick(); chk("b2b_e2", {31'd0, cpu_dvalid}, 32'd1);
      cpu_read_en = 1'b0;
      tick(); chk("b2b_e3", {31'd0, cpu_dvalid}, 32'd0);
      chk("b2b_hit_count", 32'(hit_count), 32'd3);

      // 3: conflict on index 1
      do_read("conf1", 32'd1, 4, 32'h00C0FFEE, 2);
      do_read("conf5", 32'd5, 4, 32'hDEADBEEF, 2);
      chk("conf_miss_count", 32'(miss_count), 32'd3);

      // 4: flush beats a simultaneous read
      cpu_addr = 32'd5; cpu_read_en = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_no_accept_ren", {31'd0, mem_read_en}, 32'd0);
      chk("flush_no_accept_dv", {31'd0, cpu_dvalid}, 32'd0);
      chk("flush_miss_unchanged", 32'(miss_count), 32'd3);
      do_read("flush_rd", 32'd5, 4, 32'hDEADBEEF, 2);
      chk("flush_miss_count", 32'(miss_count), 32'd4);
      chk("sat_miss", {30'd0, sat_miss_count}, 32'd3);
      chk("sat_hit", {30'd0, sat_hit_count}, 32'd3);

      // 5: reset in the middle of a fill
      cpu_addr = 32'd2; cpu_read_en = 1'b1;
      tick();
      chk("mid_fill_ren", {31'd0, mem_read_en}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_drops_ren", {31'd0, mem_read_en}, 32'd0);
      tick();
      reset = 1'b0; cpu_read_en = 1'b0;
      chk("rst2_dvalid", {31'd0, cpu_dvalid}, 32'd0);
      chk("rst2_data", cpu_data, 32'd0);
      chk("rst2_mem_addr", mem_addr, 32'd0);
      chk("rst2_counts", {hit_count, miss_count}, 32'd0);
      ram_clr = 1'b1;
      tick();
      ram_clr = 1'b0;
      do_read("reread2", 32'd2, 4, 32'h2222_0002, 2);
      chk("reread2_miss", 32'(miss_count), 32'd1);

      // 6: longer memory delay
      dvalid_delay = 4;
      do_read("slow7", 32'd7, 7, 32'h7777_0007, 5);
      do_read("slow7_hit", 32'd7, 1, 32'h7777_0007, 0);
      do_read("line2_kept", 32'd2, 1, 32'h2222_0002, 0);
      chk("final_counts", {hit_count, miss_count}, {16'd2, 16'd2});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
